regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources.
//  - Source A: main pipeline writeback.
//  - Source B: long-latency unit (mul/div/load-miss).

---
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter for pipeline (A) and long-latency (B) writebacks.
// Fixed priority to A with starvation override for B, plus busy-bit scoreboard.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ADDR_WIDTH-1:0]    a_addr,
    input  logic [DATA_WIDTH-1:0]    a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [ADDR_WIDTH-1:0]    b_addr,
    input  logic [DATA_WIDTH-1:0]    b_data,
    input  logic                     alloc_valid,
    input  logic [ADDR_WIDTH-1:0]    alloc_addr,
    input  logic [ADDR_WIDTH-1:0]    q_addr1,
    input  logic [ADDR_WIDTH-1:0]    q_addr2,
    output logic                     q_busy1,
    output logic                     q_busy2,
    output logic                     rf_we,
    output logic [ADDR_WIDTH-1:0]    rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    output logic [2**ADDR_WIDTH-1:0] busy
);

    localparam int NREG = 2**ADDR_WIDTH;
    localparam int CW   = $clog2(STARVE_LIMIT+1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
    logic                  rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  starve;
    logic                  grant_a, grant_b;

    assign starve  = (wait_cnt_q == LIMIT);
    assign grant_a = a_valid & (~starve | ~b_valid);
    assign grant_b = b_valid & (starve | ~a_valid);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!b_valid || grant_b)
            wait_cnt_d = '0;
        else if (wait_cnt_q != LIMIT)
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_a) begin
            rf_we_d    = (a_addr != '0);
            rf_waddr_d = a_addr;
            rf_wdata_d = a_data;
        end else if (grant_b) begin
            rf_we_d    = (b_addr != '0);
            rf_waddr_d = b_addr;
            rf_wdata_d = b_data;
        end
    end

    // Set after clear so a same-cycle re-alloc keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (grant_b && b_addr != '0)
            busy_d[b_addr] = 1'b0;
        if (alloc_valid && alloc_addr != '0)
            busy_d[alloc_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign q_busy1  = busy_q[q_addr1];
    assign q_busy2  = busy_q[q_addr2];
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, arbitration, starvation,
// x0 filtering and scoreboard set/clear behaviour.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, alloc_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr, alloc_addr, q_addr1, q_addr2;
    logic [31:0] a_data, b_data;
    logic        q_busy1, q_busy2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_addr(b_addr), .b_data(b_data),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .q_addr1(q_addr1), .q_addr2(q_addr2),
        .q_busy1(q_busy1), .q_busy2(q_busy2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 0; b_valid = 0; alloc_valid = 0;
        a_addr = 0; b_addr = 0; alloc_addr = 0;
        a_data = 0; b_data = 0;
        q_addr1 = 0; q_addr2 = 0;
        tick();
        tick();
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // 1: reset mid-transfer
        a_valid = 1; a_addr = 5; a_data = 32'h55;
        alloc_valid = 1; alloc_addr = 4;
        tick();
        alloc_valid = 0;
        chk("t1_pre_we", rf_we, 1);
        chk("t1_pre_busy", busy, 32'h10);
        #2 reset = 1'b1;
        #1;
        chk("t1_async_we", rf_we, 0);
        chk("t1_async_busy", busy, 0);
        chk("t1_async_waddr", rf_waddr, 0);
        a_valid = 0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("t1_post_we", rf_we, 0);

        // 2: A only
        a_valid = 1; a_addr = 3; a_data = 32'hDEADBEEF;
        #1;
        chk("t2_a_ready", a_ready, 1);
        chk("t2_b_ready", b_ready, 0);
        tick();
        a_valid = 0;
        chk("t2_we", rf_we, 1);
        chk("t2_waddr", rf_waddr, 3);
        chk("t2_wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        chk("t2_idle_we", rf_we, 0);
        chk("t2_hold_waddr", rf_waddr, 3);
        chk("t2_hold_wdata", rf_wdata, 32'hDEADBEEF);

        // 3: contention, B forced on 5th cycle, A resumes
        a_valid = 1; a_addr = 1;
        b_valid = 1; b_addr = 2; b_data = 32'hB2;
        for (int c = 1; c <= 6; c++) begin
            a_data = 32'h100 + c;
            #1;
            chk($sformatf("t3_a_ready_c%0d", c), a_ready, (c != 5));
            chk($sformatf("t3_b_ready_c%0d", c), b_ready, (c == 5));
            tick();
            if (c == 5) b_valid = 0;
            chk($sformatf("t3_waddr_c%0d", c), rf_waddr, (c == 5) ? 2 : 1);
            chk($sformatf("t3_wdata_c%0d", c), rf_wdata,
                (c == 5) ? 32'hB2 : 32'h100 + c);
        end
        a_valid = 0;
        // counter cleared: with both valid again, A wins
        b_valid = 1;
        a_valid = 1;
        #1;
        chk("t3_cnt_clr_a", a_ready, 1);
        chk("t3_cnt_clr_b", b_ready, 0);
        a_valid = 0; b_valid = 0;
        tick();

        // 4: x0 filter
        b_valid = 1; b_addr = 0; b_data = 32'h7;
        #1;
        chk("t4_b_ready", b_ready, 1);
        tick();
        b_valid = 0;
        chk("t4_we", rf_we, 0);
        chk("t4_busy", busy, 0);

        // alloc to x0 ignored
        alloc_valid = 1; alloc_addr = 0;
        tick();
        alloc_valid = 0;
        chk("t4_alloc0_busy", busy, 0);

        // 5: scoreboard
        alloc_valid = 1; alloc_addr = 7; q_addr1 = 7;
        #1;
        chk("t5_no_bypass", q_busy1, 0);
        tick();
        alloc_valid = 0;
        chk("t5_qbusy1", q_busy1, 1);
        chk("t5_busy_set", busy, 32'h80);
        b_valid = 1; b_addr = 7; b_data = 32'h77;
        #1;
        chk("t5_b_ready", b_ready, 1);
        chk("t5_still_busy", q_busy1, 1);
        tick();
        b_valid = 0;
        chk("t5_busy_clr", busy, 0);
        chk("t5_qbusy1_clr", q_busy1, 0);
        chk("t5_we", rf_we, 1);
        chk("t5_waddr", rf_waddr, 7);
        chk("t5_wdata", rf_wdata, 32'h77);

        // 6: same-cycle set/clear
        alloc_valid = 1; alloc_addr = 9; q_addr2 = 9;
        tick();
        chk("t6_busy_pre", busy, 32'h200);
        b_valid = 1; b_addr = 9; b_data = 32'h99;
        alloc_valid = 1; alloc_addr = 9;
        #1;
        chk("t6_b_ready", b_ready, 1);
        tick();
        b_valid = 0; alloc_valid = 0;
        chk("t6_busy_kept", busy, 32'h200);
        chk("t6_qbusy2", q_busy2, 1);
        chk("t6_we", rf_we, 1);
        chk("t6_waddr", rf_waddr, 9);
        chk("t6_wdata", rf_wdata, 32'h99);

        // A transfer does not clear busy
        a_valid = 1; a_addr = 9; a_data = 32'hA9;
        tick();
        a_valid = 0;
        chk("t6_a_keeps_busy", busy, 32'h200);
        chk("t6_a_waddr", rf_waddr, 9);
        chk("t6_a_wdata", rf_wdata, 32'hA9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
